// File: rtl/stack_sequencer.sv
// Stack / call-return sequencer: single-word push/pop and multi-word PC push/pop
// against a synchronous data memory, with optional flag save/restore and bound checks.
module stack_sequencer #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    PC_WIDTH   = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 16'hFFFF,
  parameter logic [ADDR_WIDTH-1:0] SP_LIMIT   = 16'hF000,
  parameter int                    FLAG_BITS  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_op,
  input  logic                  i_save_flags,
  input  logic                  i_restore_flags,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic [FLAG_BITS-1:0]  i_flags,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_done,
  output logic [1:0]            o_error,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic [PC_WIDTH-1:0]   o_pc_new,
  output logic [FLAG_BITS-1:0]  o_flags,
  output logic                  o_flags_valid,
  output logic [ADDR_WIDTH-1:0] o_sp
);

  localparam int WORDS     = PC_WIDTH / DATA_WIDTH;
  localparam int CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TOP_SHIFT = PC_WIDTH - DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] TWO    = ADDR_WIDTH'(32'd2);
  localparam logic [ADDR_WIDTH-1:0] N_DATA = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] N_PC   = ADDR_WIDTH'(WORDS);
  localparam logic [CNT_W-1:0]      CNT_PC = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]      CNT_1  = CNT_W'(32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [PC_WIDTH-1:0] insert_flags(input logic [PC_WIDTH-1:0]  pc_val,
                                                       input logic [FLAG_BITS-1:0] fl,
                                                       input logic                 en);
    logic [PC_WIDTH-1:0] r;
    r = pc_val;
    if (en) begin
      r[PC_WIDTH-1 -: FLAG_BITS] = fl;
    end else begin
      r = pc_val;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pc_op_q, pc_op_d;
  logic                  restore_q, restore_d;
  logic [PC_WIDTH-1:0]   push_buf_q, push_buf_d;
  logic [PC_WIDTH-1:0]   pop_buf_q, pop_buf_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic [1:0]            error_q, error_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic [PC_WIDTH-1:0]   pc_new_q, pc_new_d;
  logic [FLAG_BITS-1:0]  flags_q, flags_d;
  logic                  flags_valid_q, flags_valid_d;

  logic [ADDR_WIDTH-1:0] req_words, room, avail;
  logic [PC_WIDTH-1:0]   push_word, rd_ext, merged, popped_pc;

  // Next-state, SP and registered-output computation
  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    cnt_d         = cnt_q;
    pc_op_d       = pc_op_q;
    restore_d     = restore_q;
    push_buf_d    = push_buf_q;
    pop_buf_d     = pop_buf_q;
    rd_vld_d      = re_q;
    we_d          = 1'b0;
    re_d          = 1'b0;
    addr_d        = '0;
    wdata_d       = '0;
    done_d        = 1'b0;
    error_d       = 2'b00;
    flags_valid_d = 1'b0;
    pop_data_d    = pop_data_q;
    pc_new_d      = pc_new_q;
    flags_d       = flags_q;

    req_words = i_op[1] ? N_PC : N_DATA;
    room      = sp_q - SP_LIMIT + ONE;
    avail     = SP_RESET - sp_q;
    push_word = i_op[1] ? insert_flags(i_pc, i_flags, i_save_flags)
                        : (PC_WIDTH'(i_push_data) << TOP_SHIFT);
    // Pops arrive low word first, so each word enters at the top and shifts down.
    rd_ext    = PC_WIDTH'(i_mem_rdata);
    merged    = (pop_buf_q >> DATA_WIDTH) | (rd_ext << TOP_SHIFT);
    popped_pc = insert_flags(merged, {FLAG_BITS{1'b0}}, restore_q);

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          pc_op_d   = i_op[1];
          restore_d = i_restore_flags;
          cnt_d     = i_op[1] ? CNT_PC : '0;
          if (!i_op[0]) begin
            if (room < req_words) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              error_d = 2'b01;
            end else begin
              state_d    = S_PUSH;
              we_d       = 1'b1;
              addr_d     = sp_q;
              wdata_d    = push_word[PC_WIDTH-1 -: DATA_WIDTH];
              push_buf_d = push_word << DATA_WIDTH;
            end
          end else begin
            if (avail < req_words) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              error_d = 2'b10;
            end else begin
              state_d = S_POP;
              re_d    = 1'b1;
              addr_d  = sp_q + ONE;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        sp_d = sp_q - ONE;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNT_1;
          we_d       = 1'b1;
          addr_d     = sp_q - ONE;
          wdata_d    = push_buf_q[PC_WIDTH-1 -: DATA_WIDTH];
          push_buf_d = push_buf_q << DATA_WIDTH;
        end
      end
      S_POP: begin
        if (rd_vld_q) begin
          pop_buf_d = merged;
        end else begin
          pop_buf_d = pop_buf_q;
        end
        if (re_q) begin
          sp_d = sp_q + ONE;
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_1;
            re_d   = 1'b1;
            addr_d = sp_q + TWO;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          // Drain cycle: the last read word is on i_mem_rdata now.
          state_d = S_DONE;
          done_d  = 1'b1;
          if (pc_op_q) begin
            pc_new_d = popped_pc;
            if (restore_q) begin
              flags_d       = merged[PC_WIDTH-1 -: FLAG_BITS];
              flags_valid_d = 1'b1;
            end else begin
              flags_d = flags_q;
            end
          end else begin
            pop_data_d = i_mem_rdata;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State, SP and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= S_IDLE;
      sp_q          <= SP_RESET;
      cnt_q         <= '0;
      pc_op_q       <= 1'b0;
      restore_q     <= 1'b0;
      push_buf_q    <= '0;
      pop_buf_q     <= '0;
      rd_vld_q      <= 1'b0;
      ready_q       <= 1'b1;
      we_q          <= 1'b0;
      re_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      done_q        <= 1'b0;
      error_q       <= 2'b00;
      pop_data_q    <= '0;
      pc_new_q      <= '0;
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      cnt_q         <= cnt_d;
      pc_op_q       <= pc_op_d;
      restore_q     <= restore_d;
      push_buf_q    <= push_buf_d;
      pop_buf_q     <= pop_buf_d;
      rd_vld_q      <= rd_vld_d;
      ready_q       <= ready_d;
      we_q          <= we_d;
      re_q          <= re_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      done_q        <= done_d;
      error_q       <= error_d;
      pop_data_q    <= pop_data_d;
      pc_new_q      <= pc_new_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
    end
  end

  assign o_req_ready   = ready_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_mem_we      = we_q;
  assign o_mem_re      = re_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_pop_data    = pop_data_q;
  assign o_pc_new      = pc_new_q;
  assign o_flags       = flags_q;
  assign o_flags_valid = flags_valid_q;
  assign o_sp          = sp_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed scenarios plus randomized ops on two instances
// (default limit and a two-word stack), checked against a queue-based stack model.
module tb_stack_sequencer;

  localparam logic [15:0] LIM_A = 16'hF000;
  localparam logic [15:0] LIM_B = 16'hFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, save_f, restore_f;
  logic [1:0]  op;
  logic [15:0] push_data;
  logic [31:0] pc;
  logic [2:0]  flags_in;
  logic [15:0] rdata_a, rdata_b;

  logic        a_ready, a_we, a_re, a_done, a_fv, b_ready, b_we, b_re, b_done, b_fv;
  logic [15:0] a_addr, a_wdata, a_pop, a_sp, b_addr, b_wdata, b_pop, b_sp;
  logic [1:0]  a_err, b_err;
  logic [31:0] a_pc, b_pc;
  logic [2:0]  a_fl, b_fl;

  logic        sel_b;
  logic        m_ready, m_we, m_re, m_done, m_fv;
  logic [15:0] m_addr, m_wdata, m_pop, m_sp;
  logic [1:0]  m_err;
  logic [31:0] m_pc;
  logic [2:0]  m_fl;

  assign m_ready = sel_b ? b_ready : a_ready;
  assign m_we    = sel_b ? b_we    : a_we;
  assign m_re    = sel_b ? b_re    : a_re;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_fv    = sel_b ? b_fv    : a_fv;
  assign m_addr  = sel_b ? b_addr  : a_addr;
  assign m_wdata = sel_b ? b_wdata : a_wdata;
  assign m_pop   = sel_b ? b_pop   : a_pop;
  assign m_sp    = sel_b ? b_sp    : a_sp;
  assign m_err   = sel_b ? b_err   : a_err;
  assign m_pc    = sel_b ? b_pc    : a_pc;
  assign m_fl    = sel_b ? b_fl    : a_fl;

  stack_sequencer dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(a_ready),
    .i_op(op), .i_save_flags(save_f), .i_restore_flags(restore_f),
    .i_push_data(push_data), .i_pc(pc), .i_flags(flags_in),
    .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .o_mem_we(a_we), .o_mem_re(a_re),
    .i_mem_rdata(rdata_a), .o_done(a_done), .o_error(a_err), .o_pop_data(a_pop),
    .o_pc_new(a_pc), .o_flags(a_fl), .o_flags_valid(a_fv), .o_sp(a_sp)
  );

  stack_sequencer #(.SP_LIMIT(LIM_B)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(b_ready),
    .i_op(op), .i_save_flags(save_f), .i_restore_flags(restore_f),
    .i_push_data(push_data), .i_pc(pc), .i_flags(flags_in),
    .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .o_mem_we(b_we), .o_mem_re(b_re),
    .i_mem_rdata(rdata_b), .o_done(b_done), .o_error(b_err), .o_pop_data(b_pop),
    .o_pc_new(b_pc), .o_flags(b_fl), .o_flags_valid(b_fv), .o_sp(b_sp)
  );

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];

  // Synchronous data memories: read data appears the cycle after o_mem_re
  always @(posedge clk) begin
    if (a_re) rdata_a <= mem_a[a_addr];
    if (a_we) mem_a[a_addr] <= a_wdata;
    if (b_re) rdata_b <= mem_b[b_addr];
    if (b_we) mem_b[b_addr] <= b_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stack of words (top at back) and the held result registers.
  logic [15:0] stk[$];
  logic [15:0] held_pop;
  logic [31:0] held_pc;
  logic [2:0]  held_fl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    stk.delete();
    held_pop = 16'h0000;
    held_pc  = 32'h0000_0000;
    held_fl  = 3'b000;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", m_ready, 32'd1);
    chk("rst_sp", m_sp, 32'h0000_FFFF);
    chk("rst_we_re", {m_we, m_re}, 32'd0);
    chk("rst_done_err", {m_done, m_err, m_fv}, 32'd0);
    chk("rst_pop", m_pop, 32'd0);
    chk("rst_pc", m_pc, 32'd0);
    chk("rst_flags", m_fl, 32'd0);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Issue one request (entered #1 after an edge with the DUT idle) and check it end to end.
  task automatic do_op(input logic [1:0] op_i, input logic save_i, input logic restore_i,
                       input logic [15:0] d_i, input logic [31:0] pc_i, input logic [2:0] fl_i,
                       input bit hold);
    int n, cap, sp0, done_k, k, exp_k;
    bit is_push, is_err, exp_fv;
    logic [1:0]  exp_err;
    logic [15:0] hi, lo;
    logic [15:0] words[$];
    logic [15:0] wa[$], wd[$], ra[$];
    int          wk[$], rk[$];
    logic [1:0]  s_err;
    logic [15:0] s_sp, s_pop;
    logic [31:0] s_pc;
    logic [2:0]  s_fl;
    logic        s_fv;

    n       = op_i[1] ? 2 : 1;
    is_push = (op_i[0] == 1'b0);
    sp0     = 65535 - stk.size();
    cap     = 65535 - int'(sel_b ? LIM_B : LIM_A) + 1;
    exp_fv  = 1'b0;
    if (is_push) begin
      is_err  = (cap - stk.size()) < n;
      exp_err = is_err ? 2'b01 : 2'b00;
    end else begin
      is_err  = stk.size() < n;
      exp_err = is_err ? 2'b10 : 2'b00;
    end
    if (!is_err) begin
      if (is_push) begin
        if (op_i[1]) begin
          hi = pc_i[31:16];
          lo = pc_i[15:0];
          if (save_i) hi[15:13] = fl_i;
          words.push_back(hi);
          words.push_back(lo);
        end else begin
          words.push_back(d_i);
        end
        foreach (words[i]) stk.push_back(words[i]);
      end else if (op_i[1]) begin
        lo      = stk.pop_back();
        hi      = stk.pop_back();
        held_pc = {hi, lo};
        if (restore_i) begin
          held_fl       = hi[15:13];
          held_pc[31:29] = 3'b000;
          exp_fv        = 1'b1;
        end
      end else begin
        held_pop = stk.pop_back();
      end
    end
    exp_k = is_err ? 1 : (is_push ? n + 1 : n + 2);

    op = op_i; save_f = save_i; restore_f = restore_i;
    push_data = d_i; pc = pc_i; flags_in = fl_i;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;

    done_k = 0;
    k      = 1;
    while (k <= 12 && done_k == 0) begin
      chk("we_re_excl", m_we & m_re, 32'd0);
      if (m_we) begin wk.push_back(k); wa.push_back(m_addr); wd.push_back(m_wdata); end
      if (m_re) begin rk.push_back(k); ra.push_back(m_addr); end
      if (m_done) begin
        done_k = k;
      end else begin
        chk("busy_ready", m_ready, 32'd0);
        @(posedge clk); #1;
        k++;
      end
    end
    s_err = m_err; s_sp = m_sp; s_pop = m_pop; s_pc = m_pc; s_fl = m_fl; s_fv = m_fv;

    chk("done_cycle", done_k, exp_k);
    chk("error", s_err, exp_err);
    chk("sp", s_sp, 65535 - stk.size());
    chk("pop_data", s_pop, held_pop);
    chk("pc_new", s_pc, held_pc);
    chk("flags", s_fl, held_fl);
    chk("flags_valid", s_fv, exp_fv);
    chk("wr_count", wa.size(), (is_push && !is_err) ? n : 0);
    chk("rd_count", ra.size(), (!is_push && !is_err) ? n : 0);
    for (int i = 0; i < wa.size() && i < words.size(); i++) begin
      chk("wr_addr", wa[i], sp0 - i);
      chk("wr_data", wd[i], words[i]);
      chk("wr_cycle", wk[i], i + 1);
    end
    for (int i = 0; i < ra.size() && i < n; i++) begin
      chk("rd_addr", ra[i], sp0 + 1 + i);
      chk("rd_cycle", rk[i], i + 1);
    end

    @(posedge clk); #1;
    chk("ready_after", m_ready, 32'd1);
    chk("done_pulse", m_done, 32'd0);
    req_valid = 1'b0;
  endtask

  // Reset lands in the second write cycle of a PC push: abort with no completion.
  task automatic reset_mid_push();
    op = 2'b10; save_f = 1'b0; pc = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_2nd_we", m_we, 32'd1);
    chk("abort_2nd_addr", m_addr, 32'h0000_FFFE);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_we", m_we, 32'd0);
    chk("abort_sp", m_sp, 32'h0000_FFFF);
    chk("abort_ready", m_ready, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", m_done, 32'd0);
      chk("abort_no_we", m_we, 32'd0);
      @(posedge clk); #1;
    end
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    int r;
    sel_b = 1'b0; rst_n = 1'b0; req_valid = 1'b0; op = 2'b00;
    save_f = 1'b0; restore_f = 1'b0; push_data = 16'h0000; pc = 32'h0; flags_in = 3'b000;
    model_clear();

    do_reset();
    do_op(2'b00, 1'b0, 1'b0, 16'hBEEF, 32'h0, 3'b000, 1'b0);
    do_op(2'b01, 1'b0, 1'b0, 16'h0000, 32'h0, 3'b000, 1'b0);
    do_op(2'b10, 1'b1, 1'b0, 16'h0000, 32'h0000_1234, 3'b101, 1'b0);
    do_op(2'b11, 1'b0, 1'b1, 16'h0000, 32'h0, 3'b000, 1'b0);
    do_op(2'b01, 1'b0, 1'b0, 16'h0000, 32'h0, 3'b000, 1'b0);
    do_op(2'b11, 1'b0, 1'b0, 16'h0000, 32'h0, 3'b000, 1'b0);
    do_op(2'b00, 1'b0, 1'b0, 16'h5A5A, 32'h0, 3'b000, 1'b1);
    do_op(2'b11, 1'b0, 1'b0, 16'h0000, 32'h0, 3'b000, 1'b1);
    do_op(2'b01, 1'b0, 1'b0, 16'h0000, 32'h0, 3'b000, 1'b0);
    reset_mid_push();

    sel_b = 1'b1;
    do_reset();
    do_op(2'b10, 1'b0, 1'b0, 16'h0000, 32'h8765_4321, 3'b000, 1'b0);
    do_op(2'b00, 1'b0, 1'b0, 16'h1111, 32'h0, 3'b000, 1'b0);
    do_op(2'b11, 1'b0, 1'b0, 16'h0000, 32'h0, 3'b000, 1'b0);

    for (int s = 0; s < 2; s++) begin
      sel_b = (s == 1);
      do_reset();
      for (int i = 0; i < 150; i++) begin
        r   = $urandom_range(0, 9);
        rop = (r < 4) ? 2'b00 : (r < 6) ? 2'b10 : (r < 8) ? 2'b01 : 2'b11;
        do_op(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              $urandom, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
